// File: rtl/lcd_bus_decoder.sv
// Passive HD44780-style bus decoder: rebuilds bytes from 8-bit or 4-bit
// strobes, tracks the DDRAM address and mirrors two 16-character display rows.
module lcd_bus_decoder #(
  parameter logic [7:0] CLEAR_CHAR     = 8'h20,
  parameter int         NIBBLE_TIMEOUT = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic         byte_valid,
  output logic [7:0]   byte_data,
  output logic         byte_is_data,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         nibble_err
);

  // state | meaning
  // MODE8 | 8-bit interface, every strobe is a byte {D,4'h0}
  // HI4   | 4-bit interface, waiting for the high nibble
  // LO4   | 4-bit interface, high nibble held, waiting for the low nibble
  typedef enum logic [1:0] {MODE8, HI4, LO4} state_t;

  localparam int CW = $clog2(NIBBLE_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(NIBBLE_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          e_q, rs_q, rw_q;
  logic [3:0]    d_q;
  logic [3:0]    high_q;
  logic [CW-1:0] tmo_cnt;
  logic [6:0]    addr;

  logic          strobe;
  logic          complete;
  logic          load_hi;
  logic          timeout;
  logic [7:0]    byte_new;

  logic [6:0]    addr_d;
  logic [6:0]    addr_inc;
  logic          wr_a, wr_b, clr;

  // Reads (RW=1) are invisible to the decoder.
  assign strobe = e_q & ~LCD_E & ~rw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q  <= 1'b0;
      rs_q <= 1'b0;
      rw_q <= 1'b0;
      d_q  <= 4'h0;
    end else begin
      e_q  <= LCD_E;
      rs_q <= LCD_RS;
      rw_q <= LCD_RW;
      d_q  <= LCD_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MODE8;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    load_hi  = 1'b0;
    timeout  = 1'b0;
    byte_new = 8'h00;
    case (state_q)
      MODE8: begin
        if (strobe) begin
          complete = 1'b1;
          byte_new = {d_q, 4'h0};
          if (d_q == 4'h2) state_d = HI4;
        end
      end
      HI4: begin
        if (strobe) begin
          load_hi = 1'b1;
          state_d = LO4;
        end
      end
      LO4: begin
        if (strobe) begin
          complete = 1'b1;
          byte_new = {high_q, d_q};
          state_d  = HI4;
        end else if (tmo_cnt == '0) begin
          timeout = 1'b1;
          state_d = HI4;
        end
      end
      default: state_d = MODE8;
    endcase
  end

  // Down-counter spans exactly NIBBLE_TIMEOUT cycles spent in LO4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q  <= 4'h0;
      tmo_cnt <= '0;
    end else begin
      if (load_hi)      high_q <= d_q;
      else if (timeout) high_q <= 4'h0;
      if (load_hi)
        tmo_cnt <= TMO_LOAD;
      else if (state_q == LO4 && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - CW'(1);
    end
  end

  assign addr_inc = (addr == 7'h27) ? 7'h40 :
                    (addr == 7'h67) ? 7'h00 : addr + 7'd1;

  always_comb begin
    addr_d = addr;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    clr    = 1'b0;
    if (complete) begin
      if (rs_q) begin
        wr_a   = (addr[6:4] == 3'b000);
        wr_b   = (addr[6:4] == 3'b100);
        addr_d = addr_inc;
      end else if (byte_new[7]) begin
        addr_d = byte_new[6:0];
      end else if (byte_new == 8'h01) begin
        clr    = 1'b1;
        addr_d = 7'h00;
      end else if (byte_new[7:1] == 7'h01) begin
        addr_d = 7'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr         <= 7'h00;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
      nibble_err   <= 1'b0;
    end else begin
      addr       <= addr_d;
      byte_valid <= complete;
      nibble_err <= timeout;
      if (complete) begin
        byte_data    <= byte_new;
        byte_is_data <= rs_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_A <= {16{CLEAR_CHAR}};
      row_B <= {16{CLEAR_CHAR}};
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (clr) begin
          row_A[127-8*i -: 8] <= CLEAR_CHAR;
          row_B[127-8*i -: 8] <= CLEAR_CHAR;
        end else begin
          if (wr_a && addr[3:0] == 4'(i)) row_A[127-8*i -: 8] <= byte_new;
          if (wr_b && addr[3:0] == 4'(i)) row_B[127-8*i -: 8] <= byte_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Scoreboarded bench for lcd_bus_decoder: directed LCD bus traffic with
// expected bytes queued at issue time and checked by an independent monitor.
module tb_lcd_bus_decoder;

  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         LCD_E, LCD_RS, LCD_RW;
  logic [3:0]   LCD_D;
  logic         byte_valid, byte_is_data, nibble_err;
  logic [7:0]   byte_data;
  logic [127:0] row_A, row_B;

  int checks = 0;
  int passes = 0;
  int err_pulses = 0;
  logic [8:0] exp_q[$];

  lcd_bus_decoder #(.CLEAR_CHAR(8'h20), .NIBBLE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_D(LCD_D), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_data(byte_is_data), .row_A(row_A), .row_B(row_B),
    .nibble_err(nibble_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every byte_valid pulse.
  always @(negedge clk) begin
    if (nibble_err === 1'b1) err_pulses++;
    if (byte_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %h rs=%b expected none", byte_data, byte_is_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("byte", 128'({byte_is_data, byte_data}), 128'(e));
      end
    end
  end

  function automatic logic [127:0] str16(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_D = d; LCD_E = 1'b1;
    @(negedge clk);
    LCD_E = 1'b0;
    @(negedge clk);
  endtask

  task automatic send8(input logic rs, input logic [3:0] d);
    exp_q.push_back({rs, d, 4'h0});
    strobe(rs, 1'b0, d);
  endtask

  task automatic send4(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b});
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send4(1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rb;
    reset = 1'b1; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_D = 4'h0;
    idle(3);
    check("rst_byte_valid", 128'(byte_valid), 128'(0));
    check("rst_byte_data", 128'(byte_data), 128'(0));
    check("rst_row_A", row_A, str16(""));
    check("rst_row_B", row_B, str16(""));
    check("rst_addr", 128'(dut.addr), 128'(0));
    reset = 1'b0;
    idle(2);

    // Init sequence: three 8-bit 0x3 strobes, switch to 4-bit, then setup commands.
    send8(1'b0, 4'h3); send8(1'b0, 4'h3); send8(1'b0, 4'h3); send8(1'b0, 4'h2);
    send4(1'b0, 8'h28); send4(1'b0, 8'h0C); send4(1'b0, 8'h06); send4(1'b0, 8'h01);
    idle(2);
    check("init_row_A", row_A, str16(""));
    check("init_row_B", row_B, str16(""));
    check("init_addr", 128'(dut.addr), 128'(0));

    send4(1'b0, 8'h80);
    send_str("Cracking........");
    idle(2);
    check("line1_row_A", row_A, str16("Cracking........"));
    check("line1_addr", 128'(dut.addr), 128'(7'h10));

    send4(1'b0, 8'hC0);
    send_str("Time:00000123");
    send_str("0ns");
    idle(2);
    check("line2_row_B", row_B, str16("Time:000001230ns"));
    check("line2_addr", 128'(dut.addr), 128'(7'h50));

    // 0x27 is outside both windows; next address wraps to 0x40.
    send4(1'b0, 8'hA7);
    send4(1'b1, "X");
    idle(2);
    check("wrap27_addr", 128'(dut.addr), 128'(7'h40));
    send4(1'b1, "Y");
    idle(2);
    check("wrap27_row_B", row_B, str16("Yime:000001230ns"));
    check("wrap27_row_A", row_A, str16("Cracking........"));

    // Lone high nibble then a timeout.
    strobe(1'b1, 1'b0, 4'h7);
    idle(TMO - 3);
    check("tmo_early", 128'(err_pulses), 128'(0));
    idle(10);
    check("tmo_pulse", 128'(err_pulses), 128'(1));
    send4(1'b1, 8'h5A);
    idle(TMO + 10);
    check("tmo_after", 128'(err_pulses), 128'(1));
    rb = str16("YZme:000001230ns");
    check("tmo_row_B", row_B, rb);

    // Read strobe between nibbles of 0x41 must be ignored.
    exp_q.push_back({1'b1, 8'h41});
    strobe(1'b1, 1'b0, 4'h4);
    strobe(1'b1, 1'b1, 4'hF);
    strobe(1'b1, 1'b0, 4'h1);
    idle(2);
    check("rw_row_B", row_B, str16("YZAe:000001230ns"));
    check("rw_addr", 128'(dut.addr), 128'(7'h43));

    // 0x67 wraps to 0x00.
    send4(1'b0, 8'hE7);
    send4(1'b1, "-");
    send4(1'b1, "Q");
    idle(2);
    check("wrap67_row_A", row_A, str16("Qracking........"));
    check("wrap67_addr", 128'(dut.addr), 128'(7'h01));

    send4(1'b0, 8'h02);
    idle(2);
    check("home_addr", 128'(dut.addr), 128'(0));
    send4(1'b0, 8'h01);
    idle(2);
    check("clear_row_A", row_A, str16(""));
    check("clear_row_B", row_B, str16(""));

    // Reset asserted mid-byte, off the clock edge.
    send4(1'b1, "R");
    strobe(1'b1, 1'b0, 4'h5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_byte_data", 128'(byte_data), 128'(0));
    check("mid_rst_is_data", 128'(byte_is_data), 128'(0));
    check("mid_rst_valid_err", 128'({byte_valid, nibble_err}), 128'(0));
    check("mid_rst_row_A", row_A, str16(""));
    check("mid_rst_high", 128'(dut.high_q), 128'(0));
    check("mid_rst_addr", 128'(dut.addr), 128'(0));
    idle(3);
    reset = 1'b0;
    idle(TMO + 10);
    check("mid_rst_no_err", 128'(err_pulses), 128'(1));
    // Back in 8-bit mode: a single 0x3 strobe completes a byte.
    send8(1'b0, 4'h3);
    idle(3);
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
